// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  // Last owner of the memory port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  // One memory access as presented on the mem_* lines.
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response lines and memory-side lines of the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  // Pipeline stages plus the memory array.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // The arbiter.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; at_max_o forces a fetch win.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-first arbiter for one single-ported word memory shared by fetch and data ports.
// Define MEM_ARB_STATS_EN to add saturating conflict/fetch-stall counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  conflict_cnt_o,
  output logic [STAT_W-1:0]  if_stall_cnt_o
`endif
);

  arb_state_t        state_q, state_d;
  logic              if_gnt_c, dm_gnt_c;
  logic              at_max;
  mem_cmd_t          cmd_c;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (if_gnt_c | ~bus.if_req),
    .inc_i    (bus.if_req & ~if_gnt_c),
    .at_max_o (at_max)
  );

  // State register: last owner of the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the grant of the current cycle.
  always_comb begin
    state_d = state_q;
    if (if_gnt_c) begin
      state_d = FETCH;
    end else if (dm_gnt_c) begin
      state_d = DATA;
    end else begin
      state_d = IDLE;
    end
  end

  // Grants, memory command and response capture values.
  always_comb begin
    if_gnt_c   = 1'b0;
    dm_gnt_c   = 1'b0;
    cmd_c      = '0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    // Grants are gated by reset so nothing reaches the array while held.
    if (rst_n) begin
      if (bus.dm_req && !(bus.if_req && at_max)) begin
        dm_gnt_c = 1'b1;
      end else if (bus.if_req) begin
        if_gnt_c = 1'b1;
      end
    end

    if (dm_gnt_c) begin
      cmd_c.en    = 1'b1;
      cmd_c.we    = bus.dm_we;
      cmd_c.addr  = bus.dm_addr;
      cmd_c.wdata = bus.dm_wdata;
      cmd_c.be    = bus.dm_be;
    end else if (if_gnt_c) begin
      cmd_c.en    = 1'b1;
      cmd_c.addr  = bus.if_addr;
      cmd_c.be    = '1;
    end

    if_valid_d = if_gnt_c;
    dm_valid_d = dm_gnt_c & ~bus.dm_we;
    if (if_valid_d) begin
      if_rdata_d = bus.mem_rdata;
    end
    if (dm_valid_d) begin
      dm_rdata_d = bus.mem_rdata;
    end
  end

  // Read responses, one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.mem_en    = cmd_c.en;
  assign bus.mem_we    = cmd_c.we;
  assign bus.mem_addr  = cmd_c.addr;
  assign bus.mem_wdata = cmd_c.wdata;
  assign bus.mem_be    = cmd_c.be;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] conflict_q, conflict_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  // Saturating event counters.
  always_comb begin
    conflict_d = conflict_q;
    stall_d    = stall_q;
    if (bus.if_req && bus.dm_req && (conflict_q != '1)) begin
      conflict_d = conflict_q + STAT_W'(1);
    end
    if (bus.if_req && !if_gnt_c && (stall_q != '1)) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign if_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expectations, a negedge monitor checks them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    int unsigned due;
    logic        eig;
    logic        edg;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } cyc_exp_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem   [64];
  logic [31:0] model [64];

  cyc_exp_t cyc_q[$];
  resp_t    if_q[$];
  resp_t    dm_q[$];

  mem_port_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] if_stall_cnt;
`endif

  mem_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .if_stall_cnt_o (if_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory array driven by the arbiter's mem_* lines.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One request cycle: drive, queue expectations, update the memory model.
  task automatic cycle(input logic ir, input logic [5:0] ia,
                       input logic dr, input logic dw, input logic [5:0] da,
                       input logic [31:0] dd, input logic [3:0] db,
                       input logic eig, input logic edg, input bit kill = 1'b0);
    cyc_exp_t e;
    resp_t    r;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
    bus.dm_be    = db;
    e.due   = cyc;
    e.eig   = eig;
    e.edg   = edg;
    e.en    = eig | edg;
    e.we    = edg & dw;
    e.be    = edg ? db : (eig ? 4'hF : 4'h0);
    e.addr  = edg ? da : (eig ? ia : 6'd0);
    e.wdata = edg ? dd : 32'd0;
    cyc_q.push_back(e);
    if (eig) begin
      r.due = cyc + 1; r.data = model[ia]; if_q.push_back(r);
    end
    if (edg && !dw && !kill) begin
      r.due = cyc + 1; r.data = model[da]; dm_q.push_back(r);
    end
    if (edg && dw) begin
      for (int b = 0; b < 4; b++) if (db[b]) model[da][8*b +: 8] = dd[8*b +: 8];
    end
    if (kill) begin
      #6 rst_n = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle grant/mem checks and valid-driven response checks.
  cyc_exp_t mon_e;
  resp_t    mon_r;
  logic     exp_v;
  always @(negedge clk) begin
    if (cyc_q.size() > 0 && cyc_q[0].due == cyc) begin
      mon_e = cyc_q.pop_front();
      chk("gnt", 64'({bus.if_gnt, bus.dm_gnt}), 64'({mon_e.eig, mon_e.edg}));
      chk("mem", 64'({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
                 64'({mon_e.en, mon_e.we, mon_e.be, mon_e.addr, mon_e.wdata}));
    end
    exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
    chk("if_valid", 64'(bus.if_valid), 64'(exp_v));
    if (exp_v) begin
      mon_r = if_q.pop_front();
      chk("if_rdata", 64'(bus.if_rdata), 64'(mon_r.data));
    end
    exp_v = (dm_q.size() > 0) && (dm_q[0].due == cyc);
    chk("dm_valid", 64'(bus.dm_valid), 64'(exp_v));
    if (exp_v) begin
      mon_r = dm_q.pop_front();
      chk("dm_rdata", 64'(bus.dm_rdata), 64'(mon_r.data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] ia;
    logic [5:0] da;
    logic [7:0] if_wins;

    for (int i = 0; i < 64; i++) begin
      mem[i]   = 32'hA500_0000 | (32'(i) << 8) | 32'(i);
      model[i] = 32'hA500_0000 | (32'(i) << 8) | 32'(i);
    end
    rst_n        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_be    = '0;
    @(posedge clk);
    #1;

    // Requests while in reset: no grant, mem lines quiet, reset values.
    cycle(1'b1, 6'd3, 1'b1, 1'b1, 6'd4, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_dm_valid", 64'(bus.dm_valid), 64'd0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst_dm_rdata", 64'(bus.dm_rdata), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst_n = 1'b1;

    // Fetch only, addresses 0..7, granted every cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 6'(i), 1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    end
    idle();

    // Full write then read back.
    cycle(1'b0, 6'd0, 1'b1, 1'b1, 6'd12, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd12, 32'd0, 4'h0, 1'b0, 1'b1);
    idle();

    // Byte write (byte 1 only) then read back: A5001414 -> A500AB14.
    cycle(1'b0, 6'd0, 1'b1, 1'b1, 6'd20, 32'h0000_AB00, 4'b0010, 1'b0, 1'b1);
    cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd20, 32'd0, 4'h0, 1'b0, 1'b1);
    chk("byte_write_model", 64'(model[20]), 64'h0000_0000_A500_AB14);
    idle();

    // Contention with STARVE_MAX=3: dm dm dm if dm dm dm if.
    if_wins = 8'b1000_1000;
    ia = 6'd30;
    da = 6'd40;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, ia, 1'b1, 1'b0, da, 32'd0, 4'h0, if_wins[k], ~if_wins[k]);
      if (if_wins[k]) ia = ia + 6'd1;
      else da = da + 6'd1;
    end
    idle();

    // Reset in the grant cycle of a read: response dropped.
    cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd12, 32'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd12, 32'd0, 4'h0, 1'b0, 1'b0);
    chk("midrst_state", 64'(dut.state_q), 64'(IDLE));
    chk("midrst_dm_valid", 64'(bus.dm_valid), 64'd0);
    chk("midrst_if_valid", 64'(bus.if_valid), 64'd0);
    rst_n = 1'b1;
    cycle(1'b0, 6'd0, 1'b1, 1'b0, 6'd12, 32'd0, 4'h0, 1'b0, 1'b1);
    idle();

    // Five contention cycles from a clean counter: dm dm dm if dm.
    if_wins = 8'b0000_1000;
    ia = 6'd50;
    da = 6'd56;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, ia, 1'b1, 1'b0, da, 32'd0, 4'h0, if_wins[k], ~if_wins[k]);
      if (if_wins[k]) ia = ia + 6'd1;
      else da = da + 6'd1;
    end
`ifdef MEM_ARB_STATS_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'd5);
    chk("if_stall_cnt", 64'(if_stall_cnt), 64'd4);
`endif
    idle();
    idle();

    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("dm_q_drained", 64'(dm_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported 32-bit word memory between the instruction-fetch port and the data-access port of the pipelined core, so both stages can share one array. Grants at most one access per cycle under a data-first policy with a starvation guard for fetch. Drives the memory's enable, address, write and byte-enable lines, and returns registered read data one cycle after the grant. Sits between the IF/MEM stages and the unified memory; the pipeline uses the `*_gnt` signals as stall sources.

## Interface
- ADDR_W, 6, word-address width (64-word array)
- DATA_W, 32, data width
- STARVE_MAX, 3, number of consecutive denied fetch cycles after which fetch wins; range 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted this cycle
- if_valid  out  1  if_rdata valid; asserted in the cycle after if_gnt
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_be  in  4  byte enables for writes
- dm_gnt  out  1  data access granted this cycle
- dm_valid  out  1  dm_rdata valid; asserted in the cycle after a granted read
- dm_rdata  out  DATA_W  read data
- mem_en, mem_we  out  1 each  memory access strobe and write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- Each requester holds its req, address and write fields stable until it sees gnt high. It then drops or renews req in the next cycle.
- Grant logic is combinational from the requests, the FSM state and the starvation counter:
  - Only one request: that request is granted.
  - Both requests: dm wins, unless starve_cnt == STARVE_MAX, in which case if wins.
  - Neither request: no grant; mem_en = 0 and all mem_* outputs are 0.
- The granted port's fields drive the mem_* outputs. mem_we = dm_we & dm_gnt; mem_be = dm_gnt ? dm_be : 4'hF.
- FSM states, recording the last owner:
  - IDLE: no grant in the previous cycle.
  - FETCH: if granted in the previous cycle.
  - DATA: dm granted in the previous cycle.
  - Next state follows the current grant: none -> IDLE, if -> FETCH, dm -> DATA.
- starve_cnt is a 4-bit counter:
  - Increments when if_req = 1 and if_gnt = 0.
  - Clears when if_gnt = 1 or if_req = 0.
  - Never exceeds STARVE_MAX.
- Responses are registered:
  - On a fetch grant, if_rdata <= mem_rdata and if_valid <= 1.
  - On a data read grant, dm_rdata <= mem_rdata and dm_valid <= 1.
  - Otherwise the valid flag drops to 0 and rdata holds its last value.
- A data write produces no dm_valid. The memory commits the write on the grant edge.

## Timing
- Grant is combinational in the request cycle; read data arrives 1 cycle later.
- Throughput is one access per cycle.
- With both ports requesting continuously, fetch is granted exactly once every STARVE_MAX+1 cycles.
- Reset values: state IDLE, starve_cnt 0, if_valid 0, dm_valid 0, if_rdata 0, dm_rdata 0.
- The grant and mem_* outputs are combinational, so they also read 0 while rst_n = 0.
- Reset asserted mid-access: the pending response is discarded and valid stays 0 until the first grant after reset release. A write on the reset edge is not committed.
- A request asserted in the first cycle after reset release is granted in that cycle.

## Configuration
- MEM_ARB_STATS_EN defined: adds two 16-bit outputs.
  - conflict_cnt: increments on every cycle with if_req & dm_req.
  - if_stall_cnt: increments on every cycle with if_req & ~if_gnt.
  - Both saturate at 16'hFFFF and reset to 0.
- MEM_ARB_STATS_EN undefined: neither port nor counter exists, and arbitration behaviour is identical.

## Structure
- Shared package holds the state encoding `arb_state_t` (IDLE=2'd0, FETCH=2'd1, DATA=2'd2) and the default ADDR_W/DATA_W constants.
- One sub-module, `arb_starve_ctr`: the saturating starvation counter with clear/increment inputs and an at_max output.
- Everything else stays in the top module.

## Test plan
- Fetch only: if_req = 1, addrs 0..7 -> if_gnt high every cycle; if_valid in each following cycle with the word at the previous address.
- Data write then read: write 32'hDEADBEEF to addr 12 with be = 4'hF, then read addr 12 -> dm_valid one cycle after the read grant, dm_rdata = 32'hDEADBEEF.
- Contention, STARVE_MAX = 3, both requesting for 8 cycles -> grant sequence dm, dm, dm, if, dm, dm, dm, if.
- Byte write: be = 4'b0010, wdata = 32'h0000AB00 -> mem_be = 4'b0010 in the grant cycle and mem_we = 1.
- Reset mid-read: assert rst_n = 0 in the grant cycle -> dm_valid and if_valid stay 0, state IDLE; the next dm_req after release is granted immediately.
- With MEM_ARB_STATS_EN: 5 contention cycles -> conflict_cnt = 5 and if_stall_cnt = 4 for STARVE_MAX = 3.
